frog_sprite_update_sched: RTL

//  Batches per-sprite position/control updates for the 20-slot frog sprite core
//  and writes them into its video-slot register map during vertical blanking only.

---
 rtl/frog_sprite_update_sched.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/frog_sprite_update_sched.sv
// ---------------------------------------------------------------------------
// frog_sprite_update_sched
//   Collects per-sprite x/y/ctrl updates in a shadow table with dirty bits and
//   writes the dirty entries into the frog sprite core's slot register map
//   during vertical blanking. The slot bus is shared with a CPU pass-through
//   that is served only while the scheduler is idle.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   x, y                pixel frame counter (trigger at y==VBLANK_Y, x==0)
//   upd_valid/ready     update handshake (ready only in IDLE)
//   upd_idx/x/y/ctrl    slot index and new position/control
//   force_flush         one-cycle pulse forcing a flush
//   cpu_cs/write/addr/wr_data, cpu_ready
//                       CPU slot request, held by the CPU until cpu_ready
//   cs/write/addr/wr_data
//                       registered slot bus towards the sprite core
//   busy                flush in progress
//   overrun             sticky, a trigger arrived while a flush was running
//
// Optional build macro FROG_SCHED_STATS_EN adds the flush_cnt and wr_cnt
// outputs (16-bit wrapping counters). Without it those ports do not exist.
// ---------------------------------------------------------------------------
module frog_sprite_update_sched #(
   parameter int NSPR     = 20,
   parameter int VBLANK_Y = 480,
   parameter int REG_BASE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [4:0]  upd_idx,
   input  logic [10:0] upd_x,
   input  logic [10:0] upd_y,
   input  logic [3:0]  upd_ctrl,
   input  logic        force_flush,
   input  logic        cpu_cs,
   input  logic        cpu_write,
   input  logic [13:0] cpu_addr,
   input  logic [31:0] cpu_wr_data,
   output logic        cpu_ready,
   output logic        cs,
   output logic        write,
   output logic [13:0] addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        overrun
`ifdef FROG_SCHED_STATS_EN
   ,
   output logic [15:0] flush_cnt,
   output logic [15:0] wr_cnt
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SCAN, ST_WR_X, ST_WR_Y, ST_WR_CTRL
   } state_t;

   // Slot register address: bit 13 selects the slot register window.
   function automatic logic [13:0] slot_addr(input logic [5:0] off);
      return {1'b1, 7'd0, off};
   endfunction

   state_t      state_r, state_next_s;
   logic [10:0] shx_r [NSPR];
   logic [10:0] shy_r [NSPR];
   logic [3:0]  shc_r [NSPR];
   logic [NSPR-1:0] dirty_r;
   logic [4:0]  cur_idx_r, idx_next_s;
   logic        found_s;
   logic [4:0]  found_idx_s;
   logic [5:0]  base_off_s;
   logic        trigger_s;
   logic        cs_next_s, write_next_s;
   logic [13:0] addr_next_s;
   logic [31:0] data_next_s;
   logic        cpu_ready_s, upd_accept_s, clr_dirty_s, fsm_wr_s, overrun_set_s;

   assign trigger_s  = ((y == 11'(VBLANK_Y)) && (x == 11'd0)) || force_flush;
   assign base_off_s = 6'(REG_BASE) + ({1'b0, cur_idx_r} * 6'd3);
   // cpu_ready must answer in the same cycle the request is taken, so it is
   // decoded from the state register rather than registered itself.
   assign cpu_ready  = cpu_ready_s;

   // Priority encoder: lowest-index dirty slot wins (scan from the top down).
   always_comb begin
      found_s     = 1'b0;
      found_idx_s = 5'd0;
      for (int i = NSPR - 1; i >= 0; i--) begin
         found_idx_s = dirty_r[i] ? 5'(i) : found_idx_s;
         found_s     = found_s | dirty_r[i];
      end
   end

   // FSM state and latched slot index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         cur_idx_r <= 5'd0;
      end else begin
         state_r   <= state_next_s;
         cur_idx_r <= idx_next_s;
      end
   end

   // Next-state, bus decision and control strobes.
   always_comb begin
      state_next_s  = state_r;
      idx_next_s    = cur_idx_r;
      cs_next_s     = 1'b0;
      write_next_s  = 1'b0;
      addr_next_s   = 14'd0;
      data_next_s   = 32'd0;
      cpu_ready_s   = 1'b0;
      upd_accept_s  = 1'b0;
      clr_dirty_s   = 1'b0;
      fsm_wr_s      = 1'b0;
      overrun_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            upd_accept_s = upd_valid;
            if (cpu_cs) begin
               cpu_ready_s  = 1'b1;
               cs_next_s    = 1'b1;
               write_next_s = cpu_write;
               addr_next_s  = cpu_addr;
               data_next_s  = cpu_wr_data;
            end else begin
               cpu_ready_s  = 1'b0;
            end
            if (trigger_s) begin
               state_next_s = ST_SCAN;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            overrun_set_s = trigger_s;
            if (found_s) begin
               idx_next_s   = found_idx_s;
               state_next_s = ST_WR_X;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WR_X: begin
            overrun_set_s = trigger_s;
            fsm_wr_s      = 1'b1;
            cs_next_s     = 1'b1;
            write_next_s  = 1'b1;
            addr_next_s   = slot_addr(base_off_s);
            data_next_s   = {21'd0, shx_r[cur_idx_r]};
            state_next_s  = ST_WR_Y;
         end
         ST_WR_Y: begin
            overrun_set_s = trigger_s;
            fsm_wr_s      = 1'b1;
            cs_next_s     = 1'b1;
            write_next_s  = 1'b1;
            addr_next_s   = slot_addr(base_off_s + 6'd1);
            data_next_s   = {21'd0, shy_r[cur_idx_r]};
            state_next_s  = ST_WR_CTRL;
         end
         ST_WR_CTRL: begin
            overrun_set_s = trigger_s;
            fsm_wr_s      = 1'b1;
            clr_dirty_s   = 1'b1;
            cs_next_s     = 1'b1;
            write_next_s  = 1'b1;
            addr_next_s   = slot_addr(base_off_s + 6'd2);
            data_next_s   = {28'd0, shc_r[cur_idx_r]};
            state_next_s  = ST_SCAN;
         end
         default: begin
            state_next_s  = ST_IDLE;
         end
      endcase
   end

   // Shadow table and dirty bits; out-of-range indices are accepted and dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSPR; i++) begin
            shx_r[i] <= 11'd0;
            shy_r[i] <= 11'd0;
            shc_r[i] <= 4'd0;
         end
         dirty_r <= '0;
      end else if (upd_accept_s && (upd_idx < 5'(NSPR))) begin
         shx_r[upd_idx]   <= upd_x;
         shy_r[upd_idx]   <= upd_y;
         shc_r[upd_idx]   <= upd_ctrl;
         dirty_r[upd_idx] <= 1'b1;
      end else if (clr_dirty_s) begin
         dirty_r[cur_idx_r] <= 1'b0;
      end
   end

   // Registered slot bus and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs        <= 1'b0;
         write     <= 1'b0;
         addr      <= 14'd0;
         wr_data   <= 32'd0;
         busy      <= 1'b0;
         upd_ready <= 1'b1;
         overrun   <= 1'b0;
      end else begin
         cs        <= cs_next_s;
         write     <= write_next_s;
         addr      <= addr_next_s;
         wr_data   <= data_next_s;
         busy      <= (state_next_s != ST_IDLE);
         upd_ready <= (state_next_s == ST_IDLE);
         overrun   <= overrun | overrun_set_s;
      end
   end

`ifdef FROG_SCHED_STATS_EN
   logic wrote_r;

   // Flush/write statistics; a flush counts only if it wrote at least one slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrote_r   <= 1'b0;
         flush_cnt <= 16'd0;
         wr_cnt    <= 16'd0;
      end else begin
         if (fsm_wr_s) begin
            wr_cnt <= wr_cnt + 16'd1;
         end
         if (state_r == ST_IDLE) begin
            wrote_r <= 1'b0;
         end else if ((state_r == ST_SCAN) && found_s) begin
            wrote_r <= 1'b1;
         end else if ((state_r == ST_SCAN) && wrote_r) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
